// File: rtl/zap_mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package zap_mult_arb_pkg;

    localparam int NUM_REQ      = 2;
    localparam int PTR_W        = $clog2(NUM_REQ);
    localparam int DATA_W       = 32;
    localparam int MAX_WAIT_DEF = 15;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_RESP  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    // One multiply-accumulate job: rm * rs + rn
    typedef struct packed {
        logic [DATA_W-1:0] rm;
        logic [DATA_W-1:0] rn;
        logic [DATA_W-1:0] rs;
    } mul_op_t;

    function automatic logic [PTR_W-1:0] oh2idx(input logic [NUM_REQ-1:0] oh);
        oh2idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (oh[i]) oh2idx = oh2idx | PTR_W'(i);
    endfunction

endpackage

// File: rtl/zap_mult_arbiter_if.sv
// Requester, response and multiplier-side signals of the arbiter.
interface zap_mult_arbiter_if;
    import zap_mult_arb_pkg::*;

    logic [NUM_REQ-1:0] i_req;
    logic [DATA_W-1:0]  i_rm0, i_rn0, i_rs0;
    logic [DATA_W-1:0]  i_rm1, i_rn1, i_rs1;
    logic [NUM_REQ-1:0] o_gnt;
    logic [NUM_REQ-1:0] o_rsp_valid;
    logic [NUM_REQ-1:0] i_rsp_ready;
    logic [DATA_W-1:0]  o_rsp_data;
    logic               i_flush;
    logic               o_err;
    logic               o_busy;
    logic               o_mul_start;
    logic               o_mul_clear;
    logic [DATA_W-1:0]  o_mul_rm, o_mul_rn, o_mul_rs;
    logic [DATA_W-1:0]  i_mul_rd;
    logic               i_mul_busy;

    modport slave (
        input  i_req, i_rm0, i_rn0, i_rs0, i_rm1, i_rn1, i_rs1,
        input  i_rsp_ready, i_flush, i_mul_rd, i_mul_busy,
        output o_gnt, o_rsp_valid, o_rsp_data, o_err, o_busy,
        output o_mul_start, o_mul_clear, o_mul_rm, o_mul_rn, o_mul_rs
    );

    modport master (
        output i_req, i_rm0, i_rn0, i_rs0, i_rm1, i_rn1, i_rs1,
        output i_rsp_ready, i_flush, i_mul_rd, i_mul_busy,
        input  o_gnt, o_rsp_valid, o_rsp_data, o_err, o_busy,
        input  o_mul_start, o_mul_clear, o_mul_rm, o_mul_rn, o_mul_rs
    );

endinterface

// File: rtl/zap_mult_arb_pick.sv
// Grant picker: first active request at or after the pointer wins.
module zap_mult_arb_pick
    import zap_mult_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic             found;
    logic [PTR_W-1:0] k;

    // NUM_REQ is a power of two, so the index wraps by plain overflow
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = ptr + PTR_W'(i);
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zap_mult_arbiter.sv
// Shares one multi-cycle multiplier between two requesters with watchdog and flush.
// ZAP_MULT_ARB_RR_EN selects round-robin arbitration; otherwise port 0 has fixed priority.
module zap_mult_arbiter
    import zap_mult_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
)(
    input  logic               i_clk,
    input  logic               i_reset,
    zap_mult_arbiter_if.slave  bus
);

    localparam int               CNT_W  = $clog2(MAX_WAIT + 2);
    localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(MAX_WAIT);

    logic [2:0]                st, st_nxt;
    mul_op_t [NUM_REQ-1:0]     req_op;
    mul_op_t                   op_q;
    logic [PTR_W-1:0]          own_q;
    logic [PTR_W-1:0]          ptr;
    logic [NUM_REQ-1:0]        pick_gnt, gnt;
    logic [CNT_W-1:0]          wd_cnt;
    logic [DATA_W-1:0]         rsp_q;
    logic                      start, clear, err, cap;

    assign req_op[0] = {bus.i_rm0, bus.i_rn0, bus.i_rs0};
    assign req_op[1] = {bus.i_rm1, bus.i_rn1, bus.i_rs1};

`ifdef ZAP_MULT_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            ptr_q <= '0;
        else if (|gnt)
            ptr_q <= oh2idx(gnt) + PTR_W'(1);
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    zap_mult_arb_pick u_pick (
        .req (bus.i_req),
        .ptr (ptr),
        .gnt (pick_gnt)
    );

    // Grants only leave IDLE; a flush in the same cycle wins over them
    assign gnt = (st == ST_IDLE && !bus.i_flush && !i_reset) ? pick_gnt : '0;

    always_comb begin
        st_nxt = st;
        start  = 1'b0;
        clear  = 1'b0;
        err    = 1'b0;
        cap    = 1'b0;
        case (st)
            ST_IDLE: begin
                if (|gnt) st_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (bus.i_flush) begin
                    clear  = 1'b1;
                    st_nxt = ST_DRAIN;
                end else begin
                    start  = 1'b1;
                    st_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.i_flush) begin
                    clear  = 1'b1;
                    st_nxt = ST_DRAIN;
                end else if (!bus.i_mul_busy) begin
                    cap    = 1'b1;
                    st_nxt = ST_RESP;
                end else if (wd_cnt > WD_LIM) begin
                    err    = 1'b1;
                    clear  = 1'b1;
                    st_nxt = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (bus.i_flush || bus.i_rsp_ready[own_q]) st_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!bus.i_mul_busy) st_nxt = ST_IDLE;
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    // wd_cnt holds the 1-based index of the current WAIT cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            st     <= ST_IDLE;
            op_q   <= '0;
            own_q  <= '0;
            wd_cnt <= '0;
            rsp_q  <= '0;
        end else begin
            st <= st_nxt;
            if (|gnt) begin
                op_q  <= req_op[oh2idx(gnt)];
                own_q <= oh2idx(gnt);
            end
            if (st == ST_ISSUE)
                wd_cnt <= CNT_W'(1);
            else if (st == ST_WAIT)
                wd_cnt <= wd_cnt + CNT_W'(1);
            else
                wd_cnt <= '0;
            if (cap)
                rsp_q <= bus.i_mul_rd;
        end
    end

    assign bus.o_gnt       = gnt;
    assign bus.o_rsp_valid = (st == ST_RESP && !bus.i_flush) ? (NUM_REQ'(1) << own_q) : '0;
    assign bus.o_rsp_data  = rsp_q;
    assign bus.o_busy      = (st != ST_IDLE);
    assign bus.o_mul_start = start & ~i_reset;
    assign bus.o_mul_clear = clear & ~i_reset;
    assign bus.o_err       = err   & ~i_reset;
    assign bus.o_mul_rm    = op_q.rm;
    assign bus.o_mul_rn    = op_q.rn;
    assign bus.o_mul_rs    = op_q.rs;

endmodule
